// File: rtl/bus_arbiter_if.sv
// Bus-arbitration handshake between the bus masters and bus_arbiter.
// The master modport is the requesting side and the slave modport is the arbiter side.
interface bus_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] lock;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] owner;
    logic            bus_busy;
    logic [NREQ-1:0] revoke;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  owner,
        input  bus_busy,
        input  revoke
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output owner,
        output bus_busy,
        output revoke
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin tristate-bus arbiter with a one-cycle turnaround and a tenure watchdog.
// Define BUS_ARBITER_LOCK_EN so that an owner holding its lock bit is never revoked.
module bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_TENURE = 16,
    parameter int IDXW       = 3
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    localparam logic [7:0]    MAX_T   = 8'(MAX_TENURE);
    localparam logic [IDXW:0] NREQ_W  = (IDXW+1)'(NREQ);
    localparam logic [IDXW:0] ONE_W   = (IDXW+1)'(1);

    state_t            state;
    logic [IDXW-1:0]   rr_ptr;
    logic [NREQ-1:0]   penalty;
    logic [7:0]        tenure;

    logic [NREQ-1:0]   eligible;
    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [NREQ-1:0]   pick_onehot;
    logic [IDXW-1:0]   pick;
    logic              pick_valid;
    logic [IDXW:0]     sum;
    logic [IDXW:0]     owner_inc;
    logic [IDXW-1:0]   next_ptr;
    logic              owner_req;

`ifdef BUS_ARBITER_LOCK_EN
    logic locked;
    logic owner_lock;
    assign owner_lock = |(bus.lock & bus.gnt);
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // Rotate the eligible set so that bit 0 is rr_ptr; the first set bit is the winner.
    always_comb begin
        eligible   = bus.req & ~penalty;
        doubled    = {eligible, eligible} >> rr_ptr;
        rotated    = doubled[NREQ-1:0];
        pick       = '0;
        pick_valid = 1'b0;
        sum        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_valid && rotated[k]) begin
                pick_valid = 1'b1;
                sum        = {1'b0, rr_ptr} + (IDXW+1)'(k);
                if (sum >= NREQ_W) sum = sum - NREQ_W;
                pick = sum[IDXW-1:0];
            end
        end
        pick_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pick_onehot[i] = (pick == IDXW'(i));
        end
        owner_inc = {1'b0, bus.owner} + ONE_W;
        next_ptr  = (owner_inc == NREQ_W) ? '0 : owner_inc[IDXW-1:0];
        owner_req = |(bus.req & bus.gnt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bus.gnt      <= '0;
            bus.owner    <= '0;
            bus.bus_busy <= 1'b0;
            bus.revoke   <= '0;
            rr_ptr       <= '0;
            tenure       <= '0;
            penalty      <= '0;
`ifdef BUS_ARBITER_LOCK_EN
            locked       <= 1'b0;
`endif
        end else begin
            bus.revoke <= '0;
            penalty    <= penalty & bus.req;
            case (state)
                // TURN is the dead gnt=0 cycle; arbitrating during it keeps the owner gap at one cycle.
                IDLE, TURN: begin
                    if (pick_valid) begin
                        bus.gnt      <= pick_onehot;
                        bus.owner    <= pick;
                        bus.bus_busy <= 1'b1;
                        tenure       <= 8'd1;
                        state        <= OWN;
`ifdef BUS_ARBITER_LOCK_EN
                        locked       <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        bus.gnt      <= '0;
                        bus.bus_busy <= 1'b0;
                        rr_ptr       <= next_ptr;
                        state        <= TURN;
                    end
`ifdef BUS_ARBITER_LOCK_EN
                    else if (owner_lock) begin
                        if (tenure != MAX_T) tenure <= tenure + 8'd1;
                        locked <= 1'b1;
                    end else if (locked) begin
                        tenure <= 8'd1;
                        locked <= 1'b0;
                    end
`endif
                    else if (tenure == MAX_T) begin
                        bus.gnt      <= '0;
                        bus.bus_busy <= 1'b0;
                        bus.revoke   <= bus.gnt;
                        penalty      <= (penalty & bus.req) | bus.gnt;
                        rr_ptr       <= next_ptr;
                        state        <= TURN;
                    end else begin
                        tenure <= tenure + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared 32-bit address/databus between bus masters: processor, DMA engine, and spare master slots.
- Exactly one master owns the tristate bus at a time.
- One-cycle dead turnaround between owners to prevent databus contention.
- Watchdog revokes a grant held longer than MAX_TENURE cycles.
- Sits beside the ram/io slaves; each master gates its bus drivers with its own gnt bit.

Parameters:
- NREQ, 4, number of requesting masters (bit 0 = processor, bit 1 = DMA engine, 2..3 spare); legal range 2..8.
- MAX_TENURE, 16, max consecutive cycles a grant is held before forced revoke; legal range 2..255.
- IDXW, 3, width of owner index output; must satisfy 2**IDXW >= NREQ.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset: clears block state when sampled 0 on posedge clk.
- req  input  NREQ  per-master bus request; held high for the whole tenure, dropped to release.
- lock  input  NREQ  per-master lock qualifier (used only with LOCK_EN).
- gnt  output  NREQ  one-hot grant; at most one bit set.
- owner  output  IDXW  index of current owner, valid when bus_busy=1.
- bus_busy  output  1  high while any gnt bit is set.
- revoke  output  NREQ  one-cycle pulse on the bit of a master whose grant was forcibly removed.

Behaviour:
- Reset (reset=0 at posedge): gnt=0, owner=0, bus_busy=0, revoke=0, rr_ptr=0, tenure counter=0, penalty mask=0, state=IDLE. Reset mid-tenure drops the grant on the next edge with no revoke pulse.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any eligible req (req & ~penalty) is high, pick the first eligible index searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Assert that gnt bit at the next edge; go to OWN. Latency from req high to gnt high is 1 cycle.
- OWN:
  - Tenure counter starts at 1 on the first grant cycle and increments each cycle.
  - If owner's req=0: gnt cleared at next edge; rr_ptr = (owner+1) mod NREQ; go to TURN.
  - Else if counter = MAX_TENURE and req still high: gnt cleared, revoke[owner] pulses 1 cycle, penalty[owner] set, rr_ptr = owner+1 mod NREQ; go to TURN.
  - Other requests arriving during OWN are ignored; no preemption.
- TURN: exactly one cycle, gnt=0 and bus_busy=0, then IDLE arbitration the following cycle. Back-to-back owners therefore see gnt gap of exactly 1 cycle. The same master re-requesting wins only if no other eligible request exists.
- penalty[i] clears on the first cycle req[i] is sampled 0; a revoked master must drop req for at least one cycle before it is eligible again.
- Simultaneous release and timeout in the same cycle: release wins, no revoke.
- owner holds its last value when bus_busy=0; it is don't-care for checking.
- bus_busy == |gnt at all times. gnt is onehot0 at all times.

Optional Feature:
- Macro: BUS_ARBITER_LOCK_EN.
- Defined: while the owner's lock bit is 1, the tenure counter saturates at MAX_TENURE and no revoke occurs. Locked transfers (e.g. DMA read-then-write pair) complete atomically. Timeout resumes MAX_TENURE cycles after lock drops (counter restarts at 1 on lock fall).
- Undefined: lock input is ignored and left unconnected internally; watchdog is always active.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> gnt=0, bus_busy=0, revoke=0; release reset -> gnt=4'b0001 one cycle later.
- Single request: req=4'b0010 at cycle 0, drop at cycle 5 -> gnt=4'b0010 cycles 1..5, gnt=0 cycle 6 (TURN), owner=1 while busy.
- Round robin: req=4'b1111 held, each master drops req 3 cycles after grant and re-raises next cycle -> grant order 0,1,2,3,0, one-cycle gap between each.
- Timeout: req[1] held high forever, MAX_TENURE=16 -> gnt[1] high exactly 16 cycles, revoke=4'b0010 for 1 cycle, gnt[1] never reasserts until req[1] drops for 1 cycle; req[2] pending is granted after TURN.
- Release coinciding with timeout: drop req[0] on tenure cycle 16 -> no revoke pulse, next grant normal.
- LOCK_EN: lock[1]=1, req[1] held 40 cycles -> no revoke, gnt[1] high 40 cycles. Without the macro, the same stimulus -> revoke at cycle 16.
